// File: rtl/edge_detect_pkg.sv
// Shared definitions for the edge-detection pipeline: controller state
// encoding, default pixel depth and default position counter widths.
package edge_detect_pkg;

    localparam int P_PIXEL_DEPTH  = 24;
    localparam int P_DEF_COL_BITS = 10;
    localparam int P_DEF_ROW_BITS = 10;

    // Controller state encoding (kept as plain constants for legacy users)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Position flags that travel with a pixel through a pipeline stage
    typedef struct packed {
        logic eol;
        logic eof;
    } pos_flags_t;

endpackage

// File: rtl/pixel_position_counter.sv
// Column/row position counter with latched frame dimensions.
// The column wraps at width-1 and bumps the row; at the final pixel of the
// frame both counters freeze until the next clear. is_eol/is_eof describe the
// position of the pixel that would be counted by the next increment.
module pixel_position_counter
    import edge_detect_pkg::*;
#(
    parameter int P_COL_BITS = P_DEF_COL_BITS,
    parameter int P_ROW_BITS = P_DEF_ROW_BITS
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET_N,
    input  logic                  I_CLEAR,
    input  logic                  I_LOAD,
    input  logic [P_COL_BITS-1:0] I_WIDTH,
    input  logic [P_ROW_BITS-1:0] I_HEIGHT,
    input  logic                  I_INC,
    output logic                  O_IS_EOL,
    output logic                  O_IS_EOF
);

    localparam logic [P_COL_BITS-1:0] C_COL_ZERO = {P_COL_BITS{1'b0}};
    localparam logic [P_COL_BITS-1:0] C_COL_ONE  = {{(P_COL_BITS-1){1'b0}}, 1'b1};
    localparam logic [P_ROW_BITS-1:0] C_ROW_ZERO = {P_ROW_BITS{1'b0}};
    localparam logic [P_ROW_BITS-1:0] C_ROW_ONE  = {{(P_ROW_BITS-1){1'b0}}, 1'b1};

    logic [P_COL_BITS-1:0] col_r;
    logic [P_ROW_BITS-1:0] row_r;
    logic [P_COL_BITS-1:0] width_r;
    logic [P_ROW_BITS-1:0] height_r;
    logic                  col_last_s;
    logic                  row_last_s;

    // Last-column / last-row decode; a zero dimension never matches
    always_comb begin
        col_last_s = (width_r  != C_COL_ZERO) && (col_r == (width_r  - C_COL_ONE));
        row_last_s = (height_r != C_ROW_ZERO) && (row_r == (height_r - C_ROW_ONE));
    end

    assign O_IS_EOL = col_last_s;
    assign O_IS_EOF = col_last_s & row_last_s;

    // Frame dimension latch
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            width_r  <= C_COL_ZERO;
            height_r <= C_ROW_ZERO;
        end else if (I_LOAD) begin
            width_r  <= I_WIDTH;
            height_r <= I_HEIGHT;
        end else begin
            width_r  <= width_r;
            height_r <= height_r;
        end
    end

    // Column/row position; freezes on the last pixel of the frame
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            col_r <= C_COL_ZERO;
            row_r <= C_ROW_ZERO;
        end else if (I_CLEAR) begin
            col_r <= C_COL_ZERO;
            row_r <= C_ROW_ZERO;
        end else if (I_INC && !(col_last_s && row_last_s)) begin
            if (col_last_s) begin
                col_r <= C_COL_ZERO;
                row_r <= row_r + C_ROW_ONE;
            end else begin
                col_r <= col_r + C_COL_ONE;
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

endmodule

// File: rtl/grayscale_stream_ctrl.sv
// Frame sequencer for the grayscale colourspace stage. Drives the stage's
// enable so its single output register acts as a one-deep stallable pipeline
// stage, and emits end-of-line / end-of-frame flags aligned to its output.
module grayscale_stream_ctrl
    import edge_detect_pkg::*;
#(
    parameter int P_COL_BITS = P_DEF_COL_BITS,
    parameter int P_ROW_BITS = P_DEF_ROW_BITS
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET_N,
    input  logic                  I_START,
    input  logic [P_COL_BITS-1:0] I_FRAME_WIDTH,
    input  logic [P_ROW_BITS-1:0] I_FRAME_HEIGHT,
    input  logic                  I_UP_VALID,
    output logic                  O_UP_READY,
    output logic                  O_GS_ENABLE,
    output logic                  O_DOWN_VALID,
    input  logic                  I_DOWN_READY,
    output logic                  O_DOWN_EOL,
    output logic                  O_DOWN_EOF,
    output logic                  O_BUSY,
    output logic                  O_DONE
);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        q_valid_r;
    pos_flags_t  flags_r;
    logic        done_r;

    logic        advance_s;
    logic        up_ready_s;
    logic        accept_s;
    logic        start_ok_s;
    logic        dims_ok_s;
    logic        is_eol_s;
    logic        is_eof_s;
    logic        last_consumed_s;

    // Handshake decode: the stage may load whenever it is empty or draining
    always_comb begin
        advance_s       = ~q_valid_r | I_DOWN_READY;
        up_ready_s      = advance_s & (state_r == ST_ACTIVE);
        accept_s        = I_UP_VALID & up_ready_s;
        start_ok_s      = I_START & (state_r == ST_IDLE);
        dims_ok_s       = (I_FRAME_WIDTH  != {P_COL_BITS{1'b0}}) &&
                          (I_FRAME_HEIGHT != {P_ROW_BITS{1'b0}});
        last_consumed_s = q_valid_r & flags_r.eof & I_DOWN_READY;
    end

    // Next-state logic for the frame sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (I_START) begin
                    state_nxt_s = dims_ok_s ? ST_ACTIVE : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (accept_s && is_eof_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_FLUSH: begin
                if (last_consumed_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and done pulse (high exactly while in DONE)
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Output stage: loads the accepted pixel's valid and position flags, holds on stall
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            q_valid_r   <= 1'b0;
            flags_r.eol <= 1'b0;
            flags_r.eof <= 1'b0;
        end else if (advance_s) begin
            q_valid_r   <= accept_s;
            flags_r.eol <= accept_s & is_eol_s;
            flags_r.eof <= accept_s & is_eof_s;
        end else begin
            q_valid_r   <= q_valid_r;
            flags_r     <= flags_r;
        end
    end

    pixel_position_counter #(
        .P_COL_BITS (P_COL_BITS),
        .P_ROW_BITS (P_ROW_BITS)
    ) u_pos (
        .I_CLK     (I_CLK),
        .I_RESET_N (I_RESET_N),
        .I_CLEAR   (start_ok_s),
        .I_LOAD    (start_ok_s),
        .I_WIDTH   (I_FRAME_WIDTH),
        .I_HEIGHT  (I_FRAME_HEIGHT),
        .I_INC     (accept_s),
        .O_IS_EOL  (is_eol_s),
        .O_IS_EOF  (is_eof_s)
    );

    assign O_GS_ENABLE  = advance_s;
    assign O_UP_READY   = up_ready_s;
    assign O_DOWN_VALID = q_valid_r;
    assign O_DOWN_EOL   = flags_r.eol;
    assign O_DOWN_EOF   = flags_r.eof;
    assign O_BUSY       = (state_r != ST_IDLE);
    assign O_DONE       = done_r;

endmodule

// File: tb/tb_grayscale_stream_ctrl.sv
// Directed bench for grayscale_stream_ctrl. Inputs change 2 time units after
// the rising edge; outputs are sampled 1 unit later, well away from the edge.
module tb_grayscale_stream_ctrl;

    logic       I_CLK = 1'b0;
    logic       I_RESET_N;
    logic       I_START;
    logic [9:0] I_FRAME_WIDTH;
    logic [9:0] I_FRAME_HEIGHT;
    logic       I_UP_VALID;
    logic       O_UP_READY;
    logic       O_GS_ENABLE;
    logic       O_DOWN_VALID;
    logic       I_DOWN_READY;
    logic       O_DOWN_EOL;
    logic       O_DOWN_EOF;
    logic       O_BUSY;
    logic       O_DONE;

    int checks = 0;
    int errors = 0;
    int acc;
    int con;
    int dones;
    int bubbles;
    logic [3:0] eol_pat;
    logic       eof_last;

    always #5 I_CLK = ~I_CLK;

    grayscale_stream_ctrl dut (
        .I_CLK          (I_CLK),
        .I_RESET_N      (I_RESET_N),
        .I_START        (I_START),
        .I_FRAME_WIDTH  (I_FRAME_WIDTH),
        .I_FRAME_HEIGHT (I_FRAME_HEIGHT),
        .I_UP_VALID     (I_UP_VALID),
        .O_UP_READY     (O_UP_READY),
        .O_GS_ENABLE    (O_GS_ENABLE),
        .O_DOWN_VALID   (O_DOWN_VALID),
        .I_DOWN_READY   (I_DOWN_READY),
        .O_DOWN_EOL     (O_DOWN_EOL),
        .O_DOWN_EOF     (O_DOWN_EOF),
        .O_BUSY         (O_BUSY),
        .O_DONE         (O_DONE)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_CLK);
        #2;
    endtask

    initial begin
        I_RESET_N = 1'b0; I_START = 1'b0; I_FRAME_WIDTH = 10'd0; I_FRAME_HEIGHT = 10'd0;
        I_UP_VALID = 1'b0; I_DOWN_READY = 1'b0;
        repeat (2) @(posedge I_CLK);
        #3;
        // reset state
        chk("rst_dv",   O_DOWN_VALID, 0);
        chk("rst_eol",  O_DOWN_EOL, 0);
        chk("rst_eof",  O_DOWN_EOF, 0);
        chk("rst_done", O_DONE, 0);
        chk("rst_rdy",  O_UP_READY, 0);
        chk("rst_busy", O_BUSY, 0);
        chk("rst_gse",  O_GS_ENABLE, 1);
        I_RESET_N = 1'b1;

        // ---- S1: W=4 H=2 full throughput
        tick(); I_START = 1'b1; I_FRAME_WIDTH = 10'd4; I_FRAME_HEIGHT = 10'd2;
        #1 chk("s1_idle_busy", O_BUSY, 0);
        tick(); I_START = 1'b0; I_UP_VALID = 1'b1; I_DOWN_READY = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            #1;
            chk("s1_rdy",  O_UP_READY,   (k < 8) ? 1 : 0);
            chk("s1_dv",   O_DOWN_VALID, (k >= 1 && k <= 8) ? 1 : 0);
            chk("s1_eol",  O_DOWN_EOL,   (k == 4 || k == 8) ? 1 : 0);
            chk("s1_eof",  O_DOWN_EOF,   (k == 8) ? 1 : 0);
            chk("s1_done", O_DONE,       (k == 9) ? 1 : 0);
            chk("s1_busy", O_BUSY,       (k <= 9) ? 1 : 0);
            chk("s1_gse",  O_GS_ENABLE,  1);
            tick();
        end
        I_UP_VALID = 1'b0;

        // ---- S2: W=3 H=1 with 5-cycle downstream stall
        tick(); I_START = 1'b1; I_FRAME_WIDTH = 10'd3; I_FRAME_HEIGHT = 10'd1;
        tick(); I_START = 1'b0; I_UP_VALID = 1'b1;
        acc = 0; con = 0; dones = 0; eof_last = 1'b0;
        for (int k = 0; k < 12; k++) begin
            I_DOWN_READY = (k >= 6);
            #1;
            if (k >= 1 && k <= 5) begin
                chk("s2_stall_rdy", O_UP_READY, 0);
                chk("s2_stall_gse", O_GS_ENABLE, 0);
                chk("s2_stall_dv",  O_DOWN_VALID, 1);
                chk("s2_stall_eol", O_DOWN_EOL, 0);
            end
            if (I_UP_VALID && O_UP_READY) acc++;
            if (O_DOWN_VALID && I_DOWN_READY) begin
                con++;
                if (con == 3) eof_last = O_DOWN_EOF;
            end
            if (O_DONE) dones++;
            tick();
        end
        I_UP_VALID = 1'b0;
        chk("s2_accepts",  acc, 3);
        chk("s2_consumes", con, 3);
        chk("s2_eof_last", eof_last, 1);
        chk("s2_dones",    dones, 1);

        // ---- S3: W=2 H=2 with toggling upstream valid
        tick(); I_START = 1'b1; I_FRAME_WIDTH = 10'd2; I_FRAME_HEIGHT = 10'd2; I_DOWN_READY = 1'b1;
        tick(); I_START = 1'b0;
        acc = 0; con = 0; dones = 0; bubbles = 0; eol_pat = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            I_UP_VALID = (k % 2 == 0);
            #1;
            if (!O_DOWN_VALID && con >= 1 && con < 4) bubbles++;
            if (I_UP_VALID && O_UP_READY) acc++;
            if (O_DOWN_VALID && I_DOWN_READY) begin
                if (con < 4) eol_pat[con] = O_DOWN_EOL;
                con++;
            end
            if (O_DONE) dones++;
            tick();
        end
        I_UP_VALID = 1'b0;
        chk("s3_accepts", acc, 4);
        chk("s3_consumes", con, 4);
        chk("s3_eol_pat", eol_pat, 4'b1010);
        chk("s3_bubbles", bubbles, 3);
        chk("s3_dones", dones, 1);

        // ---- S4: zero width goes straight to DONE
        tick(); I_START = 1'b1; I_FRAME_WIDTH = 10'd0; I_FRAME_HEIGHT = 10'd5; I_UP_VALID = 1'b1;
        #1 chk("s4_rdy0", O_UP_READY, 0);
        tick(); I_START = 1'b0;
        #1;
        chk("s4_done",  O_DONE, 1);
        chk("s4_busy",  O_BUSY, 1);
        chk("s4_rdy1",  O_UP_READY, 0);
        tick();
        #1;
        chk("s4_done_end", O_DONE, 0);
        chk("s4_busy_end", O_BUSY, 0);
        chk("s4_rdy2",     O_UP_READY, 0);
        I_UP_VALID = 1'b0;

        // ---- S5: restart attempt mid-frame is ignored
        tick(); I_START = 1'b1; I_FRAME_WIDTH = 10'd2; I_FRAME_HEIGHT = 10'd1;
        tick(); I_FRAME_WIDTH = 10'd7; I_FRAME_HEIGHT = 10'd3; I_UP_VALID = 1'b1;
        #1 chk("s5_rdy", O_UP_READY, 1);
        tick(); I_START = 1'b0;
        #1;
        chk("s5_dv0",  O_DOWN_VALID, 1);
        chk("s5_eol0", O_DOWN_EOL, 0);
        tick();
        #1;
        chk("s5_dv1",  O_DOWN_VALID, 1);
        chk("s5_eol1", O_DOWN_EOL, 1);
        chk("s5_eof1", O_DOWN_EOF, 1);
        chk("s5_rdy1", O_UP_READY, 0);
        tick();
        #1 chk("s5_done", O_DONE, 1);
        I_UP_VALID = 1'b0;

        // ---- S6: reset during row 1 of W=4 H=4, then fresh frame
        tick(); I_START = 1'b1; I_FRAME_WIDTH = 10'd4; I_FRAME_HEIGHT = 10'd4;
        tick(); I_START = 1'b0; I_UP_VALID = 1'b1;
        repeat (6) tick();
        I_RESET_N = 1'b0;
        #1;
        chk("s6_dv",   O_DOWN_VALID, 0);
        chk("s6_busy", O_BUSY, 0);
        chk("s6_rdy",  O_UP_READY, 0);
        chk("s6_gse",  O_GS_ENABLE, 1);
        chk("s6_done", O_DONE, 0);
        I_UP_VALID = 1'b0;
        tick();
        #1 chk("s6_done_hold", O_DONE, 0);
        I_RESET_N = 1'b1;
        tick(); I_START = 1'b1; I_FRAME_WIDTH = 10'd2; I_FRAME_HEIGHT = 10'd1;
        tick(); I_START = 1'b0; I_UP_VALID = 1'b1;
        #1 chk("s6_re_rdy", O_UP_READY, 1);
        tick();
        #1;
        chk("s6_re_dv0",  O_DOWN_VALID, 1);
        chk("s6_re_eol0", O_DOWN_EOL, 0);
        tick();
        #1;
        chk("s6_re_eol1", O_DOWN_EOL, 1);
        chk("s6_re_eof1", O_DOWN_EOF, 1);
        tick();
        #1 chk("s6_re_done", O_DONE, 1);
        I_UP_VALID = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grayscale_stream_ctrl.md
Name: grayscale_stream_ctrl

Overview:
Sequences the grayscale colourspace stage for one frame at a time. It accepts RGB pixels over a valid/ready handshake and drives the grayscale stage's enable so that its single output register behaves as a one-deep, stallable pipeline stage. It tracks column and row position and emits end-of-line and end-of-frame flags aligned to the grayscale output. It sits between the pixel input interface and the edge-detection kernel front end.

Parameters:
P_COL_BITS, 10, width of the column counter and of I_FRAME_WIDTH (max width 1023).
P_ROW_BITS, 10, width of the row counter and of I_FRAME_HEIGHT (max height 1023).

Ports:
I_CLK  input  1  clock; all logic is on the rising edge.
I_RESET_N  input  1  asynchronous, active-low reset.
I_START  input  1  one-cycle pulse that begins a frame; ignored unless the block is IDLE.
I_FRAME_WIDTH  input  P_COL_BITS  pixels per line; latched on an accepted I_START.
I_FRAME_HEIGHT  input  P_ROW_BITS  lines per frame; latched on an accepted I_START.
I_UP_VALID  input  1  upstream RGB pixel is valid.
O_UP_READY  output  1  controller accepts the upstream pixel this cycle.
O_GS_ENABLE  output  1  enable to the grayscale stage; its output register loads when high.
O_DOWN_VALID  output  1  grayscale output pixel is valid.
I_DOWN_READY  input  1  downstream consumes the pixel.
O_DOWN_EOL  output  1  the current output pixel is the last pixel of its line.
O_DOWN_EOF  output  1  the current output pixel is the last pixel of the frame.
O_BUSY  output  1  high in every state except IDLE.
O_DONE  output  1  one-cycle pulse after the final pixel is consumed.

Behaviour:
- Reset (I_RESET_N=0, asynchronous):
  - State returns to IDLE.
  - All registered outputs clear: O_DOWN_VALID, O_DOWN_EOL, O_DOWN_EOF, O_DONE.
  - Column and row counters, accepted-pixel state and latched dimensions all clear to 0.
  - O_UP_READY=0 and O_BUSY=0 because the block is IDLE.
  - O_GS_ENABLE=1, since advance = ~q_valid. This lets the grayscale stage's own reset take effect, because that reset only acts while enable is high.
- States: IDLE, ACTIVE, FLUSH, DONE.
  - IDLE -> ACTIVE on I_START when width!=0 and height!=0. Dimensions are latched and counters cleared.
  - IDLE -> DONE on I_START when either dimension is 0. No pixels are accepted.
  - ACTIVE -> FLUSH on the cycle the last pixel (col=W-1, row=H-1) is accepted.
  - FLUSH -> DONE when O_DOWN_VALID & O_DOWN_EOF & I_DOWN_READY.
  - DONE -> IDLE unconditionally after 1 cycle. O_DONE=1 only in DONE.
- Pipeline stage:
  - q_valid is the registered copy of O_DOWN_VALID.
  - advance = ~q_valid | I_DOWN_READY.
  - O_GS_ENABLE = advance, combinational.
  - O_UP_READY = advance & (state==ACTIVE), combinational.
  - accept = I_UP_VALID & O_UP_READY.
  - When advance is high: q_valid <= accept, and EOL/EOF are registered from the position of the accepted pixel.
  - When advance is low: all stage registers hold. The grayscale register also holds because its enable is low.
- Latency: a pixel accepted in cycle N appears on O_DOWN_VALID in cycle N+1, together with its grayscale value.
- Throughput: 1 pixel per cycle while the downstream holds I_DOWN_READY=1.
- Once O_DOWN_VALID=1, the output pixel, O_DOWN_EOL and O_DOWN_EOF are stable until consumed.
- Counters:
  - The column counter increments on accept and wraps to 0 at W-1, at which point the row counter increments.
  - At the last pixel of the frame both counters stop; they are cleared on the next accepted I_START.
- EOL is set for col==W-1; EOF is set for col==W-1 & row==H-1.
- Simultaneous accept and consume in one cycle is legal: the stage is refilled with no bubble.
- I_START during ACTIVE, FLUSH or DONE is ignored; I_FRAME_WIDTH and I_FRAME_HEIGHT are not re-latched.
- I_UP_VALID while IDLE or FLUSH is not accepted (O_UP_READY=0).
- Reset mid-frame abandons the frame with no O_DONE pulse.

Decomposition:
- Shared package edge_detect_pkg holds:
  - the state encoding constants (IDLE=2'd0, ACTIVE=2'd1, FLUSH=2'd2, DONE=2'd3);
  - the P_PIXEL_DEPTH default (24);
  - the default counter widths.
- One sub-module, pixel_position_counter:
  - column/row counter with increment enable, clear, and latched W/H;
  - outputs is_eol and is_eof;
  - the same sub-module is reused by the later line-buffer controllers.
- The FSM and pipeline-valid logic stay in grayscale_stream_ctrl.

Test Plan:
- Reset, then I_START with W=4, H=2, then I_UP_VALID=1 and I_DOWN_READY=1 continuously -> O_UP_READY=1 for 8 consecutive cycles; O_DOWN_VALID=1 for 8 cycles starting 1 cycle after the first accept; O_DOWN_EOL at outputs 4 and 8; O_DOWN_EOF at output 8 only; O_DONE pulses 1 cycle after output 8 is consumed; O_BUSY=0 afterwards.
- W=3, H=1, I_DOWN_READY=0 for 5 cycles after the first accept -> O_UP_READY=0 and O_GS_ENABLE=0 while O_DOWN_VALID=1; the grayscale output stays stable; after release, all 3 pixels are delivered with none lost or duplicated.
- I_UP_VALID toggling 1,0,1,0 with W=2, H=2 -> exactly 4 accepts; O_DOWN_VALID contains bubbles; EOL on the 2nd and 4th outputs; O_DONE pulses once.
- I_START with W=0, H=5 -> DONE one cycle later, O_DONE=1 for 1 cycle, O_UP_READY never asserted.
- I_START pulsed again mid-frame with W=7 -> ignored; the frame completes with the original W and H.
- I_RESET_N asserted low during row 1 of a W=4, H=4 frame -> immediately O_DOWN_VALID=0, O_BUSY=0, O_UP_READY=0, O_GS_ENABLE=1, no O_DONE; a fresh I_START after release restarts at col=0, row=0.
